// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with majority-vote sampling
// and a first-word-fall-through receive FIFO drained by valid/ready.
// Optional macro UART_RX_CFG_BREAK_EN adds break detection (break_det port,
// BREAK state); all-zero frames are then reported as breaks, not written.

module uart_rx_cfg #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic [DIV_W-1:0]  cfg_baud_div,
    input  logic [3:0]        cfg_data_bits,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_odd,
    input  logic              cfg_stop2,
    output logic [DATA_W-1:0] m_data,
    output logic              m_parity_err,
    output logic              m_frame_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              overrun,
    output logic              busy
`ifdef UART_RX_CFG_BREAK_EN
    ,
    output logic              break_det
`endif
);

    localparam int unsigned ENTRY_W = DATA_W + 2;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PW      = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
`ifdef UART_RX_CFG_BREAK_EN
        ,
        S_BREAK
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic              r_rx_meta;
    logic              r_rx_s;
    state_t            r_state;
    logic              r_busy;
    logic [DIV_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  r_div;
    logic [3:0]        r_nbits;
    logic              r_par_en;
    logic              r_par_odd;
    logic              r_stop2;
    logic              r_s0;
    logic              r_s1;
    logic [3:0]        r_bit_idx;
    logic [DATA_W-1:0] r_data;
    logic              r_par_acc;
    logic              r_perr;
    logic              r_ferr;
`ifdef UART_RX_CFG_BREAK_EN
    logic              r_zero;
    logic              r_break_det;
    logic              w_brk;
`endif

    logic [DIV_W-1:0]  w_half;
    logic              w_smp0;
    logic              w_smp1;
    logic              w_dec;
    logic              w_end;
    logic              w_maj;
    logic [3:0]        w_nbits_cfg;
    logic              w_final;
    logic              w_done;
    logic              w_ferr_fin;
    logic              w_par_exp;
    logic              w_wr_req;
    logic [ENTRY_W-1:0] w_wr_data;

    // Bit-period timing: three samples around the bit centre, vote on the third
    assign w_half      = r_div >> 1;
    assign w_smp0      = (r_cnt == w_half - DIV_W'(1));
    assign w_smp1      = (r_cnt == w_half);
    assign w_dec       = (r_cnt == w_half + DIV_W'(1));
    assign w_end       = (r_cnt == r_div - DIV_W'(1));
    assign w_maj       = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);

    // Out-of-range data-bit counts fall back to the widest frame
    assign w_nbits_cfg = ((cfg_data_bits >= 4'd5) && (cfg_data_bits <= 4'(DATA_W)))
                         ? cfg_data_bits : 4'(DATA_W);

    // Frame completes at the vote of the last stop bit
    assign w_final     = ((r_state == S_STOP1) && !r_stop2) || (r_state == S_STOP2);
    assign w_done      = w_final && w_dec;
    assign w_ferr_fin  = r_ferr | ~w_maj;
    assign w_par_exp   = r_par_acc ^ r_par_odd;
    assign w_wr_data   = {w_ferr_fin, r_perr, r_data};

`ifdef UART_RX_CFG_BREAK_EN
    // Break: data, parity and first stop bit all voted 0
    assign w_brk       = w_done && r_zero && ((r_state == S_STOP2) || !w_maj);
    assign w_wr_req    = w_done && !w_brk;
`else
    assign w_wr_req    = w_done;
`endif

    // Two-flop synchroniser for the asynchronous rx pad
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame FSM: bit timing, sampling, data assembly and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_div     <= DIV_W'(8);
            r_nbits   <= 4'(DATA_W);
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_stop2   <= 1'b0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_par_acc <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_CFG_BREAK_EN
            r_zero      <= 1'b0;
            r_break_det <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_CFG_BREAK_EN
            r_break_det <= w_brk;
`endif
            if (r_state != S_IDLE) begin
                r_cnt <= w_end ? '0 : r_cnt + DIV_W'(1);
                if (w_smp0) r_s0 <= r_rx_s;
                if (w_smp1) r_s1 <= r_rx_s;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state   <= S_START;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_div     <= cfg_baud_div;
                        r_nbits   <= w_nbits_cfg;
                        r_par_en  <= cfg_parity_en;
                        r_par_odd <= cfg_parity_odd;
                        r_stop2   <= cfg_stop2;
                        r_bit_idx <= '0;
                        r_data    <= '0;
                        r_par_acc <= 1'b0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
`ifdef UART_RX_CFG_BREAK_EN
                        r_zero    <= 1'b1;
`endif
                    end
                end

                S_START: begin
                    if (w_dec && w_maj) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_end) begin
                        r_state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_dec) begin
                        r_data    <= r_data | (DATA_W'(w_maj) << r_bit_idx);
                        r_par_acc <= r_par_acc ^ w_maj;
`ifdef UART_RX_CFG_BREAK_EN
                        if (w_maj) r_zero <= 1'b0;
`endif
                    end
                    if (w_end) begin
                        if (r_bit_idx == r_nbits - 4'd1) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end
                end

                S_PARITY: begin
                    if (w_dec) begin
                        if (w_maj != w_par_exp) r_perr <= 1'b1;
`ifdef UART_RX_CFG_BREAK_EN
                        if (w_maj) r_zero <= 1'b0;
`endif
                    end
                    if (w_end) r_state <= S_STOP1;
                end

                S_STOP1: begin
                    if (w_dec) begin
                        if (!w_maj) r_ferr <= 1'b1;
`ifdef UART_RX_CFG_BREAK_EN
                        if (w_maj) r_zero <= 1'b0;
`endif
                    end
                    if (w_done) begin
`ifdef UART_RX_CFG_BREAK_EN
                        r_state <= w_brk ? S_BREAK : S_IDLE;
                        r_busy  <= w_brk;
`else
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end else if (r_stop2 && w_end) begin
                        r_state <= S_STOP2;
                    end
                end

                S_STOP2: begin
                    if (w_dec && !w_maj) r_ferr <= 1'b1;
                    if (w_done) begin
`ifdef UART_RX_CFG_BREAK_EN
                        r_state <= w_brk ? S_BREAK : S_IDLE;
                        r_busy  <= w_brk;
`else
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end
                end

`ifdef UART_RX_CFG_BREAK_EN
                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
`endif

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO with registered head (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic               r_m_valid;
    logic [ENTRY_W-1:0] r_head;
    logic               r_overrun;

    logic               w_full;
    logic               w_pop;
    logic               w_wr;
    logic [PW-1:0]      w_wptr_nxt;
    logic [PW-1:0]      w_rptr_nxt;
    logic [ENTRY_W-1:0] w_head_nxt;

    assign w_full     = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_pop      = r_m_valid && m_ready;
    assign w_wr       = w_wr_req && (!w_full || w_pop);
    assign w_wptr_nxt = r_wptr + PW'(w_wr);
    assign w_rptr_nxt = r_rptr + PW'(w_pop);
    // New head is the entry being written when the FIFO would otherwise be empty
    assign w_head_nxt = (w_wr && (w_rptr_nxt == r_wptr)) ? w_wr_data
                                                         : r_mem[w_rptr_nxt[AW-1:0]];

    // Storage array write port
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_wr_data;
    end

    // Pointers, head register, valid and overrun pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_m_valid <= 1'b0;
            r_head    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_wptr    <= w_wptr_nxt;
            r_rptr    <= w_rptr_nxt;
            r_m_valid <= (w_wptr_nxt != w_rptr_nxt);
            if (w_wptr_nxt != w_rptr_nxt) r_head <= w_head_nxt;
            r_overrun <= w_wr_req && w_full && !w_pop;
        end
    end

    assign m_data       = r_head[DATA_W-1:0];
    assign m_parity_err = r_head[DATA_W];
    assign m_frame_err  = r_head[DATA_W+1];
    assign m_valid      = r_m_valid;
    assign overrun      = r_overrun;
    assign busy         = r_busy;
`ifdef UART_RX_CFG_BREAK_EN
    assign break_det    = r_break_det;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed plus randomized bench for uart_rx_cfg against a frame-level model.
module tb_uart_rx_cfg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned DIV_W      = 16;
    localparam int unsigned FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic [DIV_W-1:0]  cfg_baud_div;
    logic [3:0]        cfg_data_bits;
    logic              cfg_parity_en;
    logic              cfg_parity_odd;
    logic              cfg_stop2;
    logic [DATA_W-1:0] m_data;
    logic              m_parity_err;
    logic              m_frame_err;
    logic              m_valid;
    logic              m_ready;
    logic              overrun;
    logic              busy;
`ifdef UART_RX_CFG_BREAK_EN
    logic              break_det;
`endif

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .cfg_baud_div(cfg_baud_div), .cfg_data_bits(cfg_data_bits),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2(cfg_stop2),
        .m_data(m_data), .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
        .m_valid(m_valid), .m_ready(m_ready), .overrun(overrun), .busy(busy)
`ifdef UART_RX_CFG_BREAK_EN
        , .break_det(break_det)
`endif
    );

    // Observation side: accepted beats and event counters
    logic [9:0]  obs_q[$];
    int unsigned ovr_cnt = 0;
    int unsigned brk_cnt = 0;
    int unsigned rise_cnt = 0;
    int unsigned rise_ok_cnt = 0;
    logic        prev_valid = 1'b0;
    logic        prev_busy = 1'b0;

    always @(negedge clk) begin
        if (m_valid && m_ready) obs_q.push_back({m_frame_err, m_parity_err, m_data});
        if (overrun) ovr_cnt++;
`ifdef UART_RX_CFG_BREAK_EN
        if (break_det) brk_cnt++;
`endif
        if (m_valid && !prev_valid) begin
            rise_cnt++;
            if (prev_busy && !busy) rise_ok_cnt++;
        end
        prev_valid = m_valid;
        prev_busy  = busy;
    end

    // Model side
    logic [9:0]  exp_q[$];
    int unsigned rd = 0;
    int unsigned occ = 0;
    int unsigned ovr_exp = 0;
    int unsigned brk_exp = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_new(input string tag);
        chk({tag, "_beats"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = int'(rd); i < exp_q.size(); i++)
            if (i < obs_q.size()) chk(tag, 32'(obs_q[i]), 32'(exp_q[i]));
        rd = exp_q.size();
    endtask

    task automatic drive_bit(input logic b, input int unsigned div, input bit glitch);
        for (int c = 0; c < int'(div); c++) begin
            rx = (glitch && c == int'(div / 2)) ? ~b : b;
            tick(1);
        end
    endtask

    // Send one frame and record what a correct receiver must report
    task automatic send_frame(input logic [7:0] d, input int unsigned nb_cfg,
                              input bit pen, input bit podd, input bit s2,
                              input bit pflip, input bit [1:0] sbad,
                              input int unsigned div, input bit glitch);
        int unsigned nb;
        logic [7:0]  m;
        logic        pbit;
        logic        perr;
        logic        ferr;
        bit          brk;
        nb   = (nb_cfg >= 5 && nb_cfg <= 8) ? nb_cfg : 8;
        m    = d & (8'hFF >> (8 - nb));
        pbit = (^m) ^ podd ^ pflip;
        cfg_baud_div   = DIV_W'(div);
        cfg_data_bits  = 4'(nb_cfg);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = s2;
        drive_bit(1'b0, div, glitch);
        // configuration changes mid-frame must be ignored
        cfg_baud_div   = DIV_W'($urandom_range(8, 40));
        cfg_data_bits  = 4'($urandom);
        cfg_parity_en  = 1'($urandom);
        cfg_parity_odd = 1'($urandom);
        cfg_stop2      = 1'($urandom);
        for (int b = 0; b < int'(nb); b++) drive_bit(m[b], div, glitch);
        if (pen) drive_bit(pbit, div, glitch);
        cfg_baud_div   = DIV_W'(div);
        cfg_data_bits  = 4'(nb_cfg);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = s2;
        drive_bit(~sbad[0], div, glitch);
        if (s2) drive_bit(~sbad[1], div, glitch);
        rx = 1'b1;
        perr = pen && (pbit != ((^m) ^ podd));
        ferr = sbad[0] || (s2 && sbad[1]);
`ifdef UART_RX_CFG_BREAK_EN
        brk = (m == 8'h00) && (!pen || !pbit) && sbad[0];
`else
        brk = 1'b0;
`endif
        if (brk) brk_exp++;
        else if (!m_ready && occ >= FIFO_DEPTH) ovr_exp++;
        else begin
            exp_q.push_back({ferr, perr, m});
            if (!m_ready) occ++;
        end
    endtask

    initial begin
        int unsigned div;
        int unsigned nbc;
        logic [7:0]  d;
        bit          pen, podd, s2, pflip, gl;
        bit [1:0]    sbad;
        int unsigned r0, r1;

        rst = 1'b1; rx = 1'b1; m_ready = 1'b1;
        cfg_baud_div = DIV_W'(16); cfg_data_bits = 4'd8;
        cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(3);

        // Reset state
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_perr", 32'(m_parity_err), 32'd0);
        chk("rst_ferr", 32'(m_frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // 8N1 0xA5, m_valid rises as the FSM leaves the frame
        r0 = rise_cnt; r1 = rise_ok_cnt;
        send_frame(8'hA5, 8, 0, 0, 0, 0, 2'b00, 16, 0);
        tick(40);
        check_new("a5");
        chk("a5_rises", rise_cnt - r0, 32'd1);
        chk("a5_rise_timing", rise_ok_cnt - r1, 32'd1);

        // 7 bits, odd parity, 2 stop: good then flipped parity
        send_frame(8'h35, 7, 1, 1, 1, 0, 2'b00, 16, 0);
        tick(40);
        send_frame(8'h35, 7, 1, 1, 1, 1, 2'b00, 16, 0);
        tick(40);
        check_new("par7o2");

        // Stop bit held low, then a clean frame
        send_frame(8'h3C, 8, 0, 0, 0, 0, 2'b01, 16, 0);
        tick(40);
        send_frame(8'h11, 8, 0, 0, 0, 0, 2'b00, 16, 0);
        tick(40);
        check_new("ferr");

        // 3-clock glitch on idle line: no frame
        rx = 1'b0; tick(3); rx = 1'b1;
        tick(40);
        chk("glitch_busy", 32'(busy), 32'd0);
        check_new("glitch");

        // Single-clock spikes at every bit centre are voted out
        send_frame(8'h5A, 8, 0, 0, 0, 0, 2'b00, 16, 1);
        tick(40);
        check_new("vote");

        // Out-of-range data-bit count means 8 bits
        send_frame(8'hC3, 15, 0, 0, 0, 0, 2'b00, 16, 0);
        tick(40);
        send_frame(8'h96, 3, 1, 0, 0, 0, 2'b00, 16, 0);
        tick(40);
        check_new("nbits_illegal");

        // All-zero frame with low stop bit
        send_frame(8'h00, 8, 0, 0, 0, 0, 2'b01, 16, 0);
        tick(40);
        check_new("zero_frame");
        chk("zero_break", brk_cnt, brk_exp);

        // Reset in the middle of a frame aborts it
        cfg_baud_div = DIV_W'(16); cfg_data_bits = 4'd8;
        cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
        drive_bit(1'b0, 16, 0);
        drive_bit(1'b1, 16, 0);
        drive_bit(1'b0, 16, 0);
        rst = 1'b1; rx = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(m_valid), 32'd0);
        tick(60);
        check_new("midrst");
        send_frame(8'h66, 8, 0, 0, 0, 0, 2'b00, 16, 0);
        tick(40);
        check_new("after_rst");

        // Overrun: 5 frames into a 4-deep FIFO with no consumer
        m_ready = 1'b0; occ = 0; r0 = ovr_cnt;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 8, 0, 0, 0, 0, 2'b00, 16, 0);
            tick(20);
        end
        chk("ovr_pulses", ovr_cnt - r0, ovr_exp);
        chk("ovr_valid", 32'(m_valid), 32'd1);
        chk("ovr_head_hold", 32'(m_data), 32'h01);
        tick(10);
        chk("ovr_head_stable", 32'(m_data), 32'h01);
        m_ready = 1'b1; occ = 0;
        tick(10);
        check_new("drain");
        chk("drain_empty", 32'(m_valid), 32'd0);

`ifdef UART_RX_CFG_BREAK_EN
        // Line held low for 12 bit times is a break
        cfg_baud_div = DIV_W'(16); cfg_data_bits = 4'd8;
        cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
        r0 = brk_cnt;
        rx = 1'b0; tick(12 * 16); rx = 1'b1;
        tick(40);
        chk("break_pulse", brk_cnt - r0, 32'd1);
        check_new("break_nowrite");
        send_frame(8'h7E, 8, 0, 0, 0, 0, 2'b00, 16, 0);
        tick(40);
        check_new("after_break");
`endif

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            div   = $urandom_range(8, 24);
            nbc   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(5, 8);
            d     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            pen   = 1'($urandom);
            podd  = 1'($urandom);
            s2    = 1'($urandom);
            pflip = ($urandom_range(0, 3) == 0);
            sbad  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            gl    = 1'($urandom);
            send_frame(d, nbc, pen, podd, s2, pflip, sbad, div, gl);
            tick(2 * div + 6);
            check_new("rand");
        end
        chk("rand_overrun", ovr_cnt, ovr_exp);
        chk("rand_break", brk_cnt, brk_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
